dispatch_window: RTL and testbench
==================================

DISPATCH_WINDOW -- requirements
Module: dispatch_window

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: number of window slots (power of two, at least 2).
REQ-002 Parameter OP_W, default 47: width of one renamed op; opcode is bits [46:43].
REQ-003 clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_ops  input  FETCH_WIDTH*OP_W: incoming bundle from rename; op k occupies bits [k*OP_W +: OP_W].
REQ-006 in_valid  input  FETCH_WIDTH: per-op valid bits, contiguous from bit 0 (for example 0011).
REQ-007 in_ready  output  FETCH_WIDTH... width 1: the whole bundle is accepted this cycle.
REQ-008 win_ops  output  FETCH_WIDTH*OP_W: registered window contents; slot 0 is the oldest op.
REQ-009 win_valid  output  FETCH_WIDTH: registered slot valid bits, always contiguous from bit 0.
REQ-010 win_used  input  FETCH_WIDTH: per-slot consume mask from the type sorter; may be non-contiguous.
REQ-011 flush  input  1: discard the window contents and any incoming bundle.
REQ-012 occupancy  output  $clog2(FETCH_WIDTH)+1: registered count of valid slots.

Note: REQ-007 is in_ready, output, width 1.

Function
REQ-013 win_ops, win_valid and occupancy SHALL be driven directly from registers, with no combinational path from any input.
REQ-014 Only used_eff = win_used & win_valid counts as consumed; win_used bits on invalid slots SHALL be ignored.
REQ-015 keep = win_valid & ~used_eff; kept ops SHALL shift toward slot 0 with their relative order preserved (stable compaction).
REQ-016 n_in = popcount(in_valid); n_keep = popcount(keep).
REQ-017 in_ready SHALL equal (n_keep + n_in <= FETCH_WIDTH) & ~flush & ~rst; this is combinational from win_used, in_valid, flush and rst.
REQ-018 in_ready SHALL be 1 when in_valid = 0, unless flush or rst is asserted.
REQ-019 On accept (in_ready & n_in > 0), in op k SHALL be written to slot n_keep + k, for k < n_in.
REQ-020 Next state SHALL be win_valid' = (1 << (n_keep + n_accepted)) - 1 and occupancy' = n_keep + n_accepted, where n_accepted = n_in if accepted, else 0.
REQ-021 If the bundle is not accepted, the window SHALL still compact; the upstream source holds the bundle unchanged until it is accepted (all-or-nothing, no partial accept).
REQ-022 Slots that become invalid SHALL hold their old data; only win_valid is authoritative.
REQ-023 Latency: an accepted op SHALL appear on win_ops/win_valid in the cycle after acceptance.
REQ-024 An op consumed in cycle t SHALL be absent from cycle t+1 onward.
REQ-025 The block SHALL support same-cycle consume and refill to a full window: the window is full, all slots are used, and 4 ops arrive -> in_ready = 1.
REQ-026 flush SHALL take priority over consume and append: next win_valid = 0 and occupancy = 0; in_ready = 0 during flush.
REQ-027 An empty window with in_valid = 0 SHALL remain empty.
REQ-028 A non-contiguous in_valid is illegal; behaviour is undefined and a simulation assertion shall flag it.

Reset
REQ-029 While rst is high at a clock edge: win_valid <= 0, occupancy <= 0, win_ops <= 0.
REQ-030 While rst is high: in_ready = 0.
REQ-031 A reset mid-operation SHALL drop all buffered ops, and any bundle presented in that cycle SHALL be lost.
REQ-032 rst SHALL have priority over flush and all other inputs.
REQ-033 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-034 Reset, then in_valid = 1111 with ops A,B,C,D -> in_ready = 1; next cycle win_valid = 1111, win_ops = A,B,C,D, occupancy = 4.
REQ-035 Window A,B,C,D; win_used = 0101; in_valid = 0011 with E,F -> in_ready = 1; next cycle slots = B,D,E,F, win_valid = 1111.
REQ-036 Window A,B,C,D; win_used = 0001; in_valid = 0011 -> in_ready = 0; next cycle slots = B,C,D, win_valid = 0111, occupancy = 3; the bundle is held and accepted the following cycle only if a slot is consumed.
REQ-037 Window A,B; win_used = 1100 (invalid slots only); in_valid = 0 -> next cycle win_valid = 0011, contents unchanged.
REQ-038 Window full; flush = 1 with in_valid = 1111 -> in_ready = 0; next cycle win_valid = 0000, occupancy = 0.
REQ-039 Window A,B,C; rst = 1 together with win_used = 0111 and in_valid = 0001 -> in_ready = 0; next cycle win_valid = 0000 and win_ops = 0.

Source files
------------

// File: rtl/dispatch_window.sv
// Dispatch window: holds renamed ops between rename and the type sorter.
// Consumed slots are squeezed out in order and new bundles append behind the survivors.
module dispatch_window #(
    parameter int FETCH_WIDTH = 4,
    parameter int OP_W        = 47
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FETCH_WIDTH*OP_W-1:0]       in_ops,
    input  logic [FETCH_WIDTH-1:0]            in_valid,
    output logic                              in_ready,
    output logic [FETCH_WIDTH*OP_W-1:0]       win_ops,
    output logic [FETCH_WIDTH-1:0]            win_valid,
    input  logic [FETCH_WIDTH-1:0]            win_used,
    input  logic                              flush,
    output logic [$clog2(FETCH_WIDTH):0]      occupancy
);

    localparam int CW = $clog2(FETCH_WIDTH) + 1;

    logic [FETCH_WIDTH*OP_W-1:0] r_win_ops;
    logic [FETCH_WIDTH-1:0]      r_win_valid;
    logic [CW-1:0]               r_occupancy;

    logic [FETCH_WIDTH-1:0]      w_used_eff;
    logic [FETCH_WIDTH-1:0]      w_keep;
    logic [CW-1:0]               w_rank [FETCH_WIDTH];
    logic [CW-1:0]               w_n_keep;
    logic [CW-1:0]               w_n_in;
    logic [CW:0]                 w_sum;
    logic                        w_accept;
    logic [CW-1:0]               w_n_acc;
    logic [CW-1:0]               w_total;
    logic [FETCH_WIDTH*OP_W-1:0] w_nxt_ops;
    logic [FETCH_WIDTH-1:0]      w_nxt_valid;
    logic [FETCH_WIDTH-1:0]      w_in_inc;

    assign win_ops   = r_win_ops;
    assign win_valid = r_win_valid;
    assign occupancy = r_occupancy;

    // Consume mask on invalid slots is meaningless and must not disturb compaction.
    assign w_used_eff = win_used & r_win_valid;
    assign w_keep     = r_win_valid & ~w_used_eff;

    // Destination rank of each kept op plus the kept and incoming op counts.
    always_comb begin : p_count
        logic [CW-1:0] v_k;
        logic [CW-1:0] v_n;
        v_k = '0;
        v_n = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_rank[i] = v_k;
            v_k = v_k + CW'(w_keep[i]);
            v_n = v_n + CW'(in_valid[i]);
        end
        w_n_keep = v_k;
        w_n_in   = v_n;
    end

    // All-or-nothing acceptance: the whole bundle must fit behind the survivors.
    always_comb begin
        w_sum    = {1'b0, w_n_keep} + {1'b0, w_n_in};
        in_ready = (w_sum <= (CW+1)'(FETCH_WIDTH)) & ~flush & ~rst;
        w_accept = in_ready & (w_n_in != '0);
        w_n_acc  = w_accept ? w_n_in : '0;
        w_total  = w_n_keep + w_n_acc;
    end

    // Next window image: stable compaction of kept ops, then appended bundle.
    always_comb begin
        w_nxt_ops   = r_win_ops;
        w_nxt_valid = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            w_nxt_valid[j] = CW'(j) < w_total;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (w_keep[i] && (w_rank[i] == CW'(j)))
                    w_nxt_ops[j*OP_W +: OP_W] = r_win_ops[i*OP_W +: OP_W];
            end
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (w_accept && in_valid[k] &&
                    ((w_n_keep + CW'(k)) == CW'(j)))
                    w_nxt_ops[j*OP_W +: OP_W] = in_ops[k*OP_W +: OP_W];
            end
        end
    end

    // Window state; reset beats flush, flush beats consume and append.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_ops   <= '0;
            r_win_valid <= '0;
            r_occupancy <= '0;
        end else if (flush) begin
            r_win_valid <= '0;
            r_occupancy <= '0;
        end else begin
            r_win_ops   <= w_nxt_ops;
            r_win_valid <= w_nxt_valid;
            r_occupancy <= w_total;
        end
    end

    assign w_in_inc = in_valid + FETCH_WIDTH'(1);

    // Upstream must present valid bits packed from bit 0.
    a_in_valid_contig : assert property (
        @(posedge clk) disable iff (rst) ((in_valid & w_in_inc) == '0)
    );

endmodule

// File: tb/tb_dispatch_window.sv
// Directed bench for dispatch_window.
// Each step drives inputs, checks in_ready, clocks, then checks the window.
module tb_dispatch_window;

    localparam int FW = 4;
    localparam int OW = 47;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW*OW-1:0]  in_ops;
    logic [FW-1:0]     in_valid;
    logic              in_ready;
    logic [FW*OW-1:0]  win_ops;
    logic [FW-1:0]     win_valid;
    logic [FW-1:0]     win_used;
    logic              flush;
    logic [2:0]        occupancy;

    int checks = 0;
    int errors = 0;

    dispatch_window #(.FETCH_WIDTH(FW), .OP_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ops    (in_ops),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_ops   (win_ops),
        .win_valid (win_valid),
        .win_used  (win_used),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] mk(input int n);
        logic [31:0] v;
        v = n;
        return {v[3:0], 43'(n * 1000 + 7)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [OW-1:0] A, B, C, D, E, F, G, H, I, J, K, L, M, N;
    logic [3*OW-1:0] lo3;

    initial begin
        A = mk(1);  B = mk(2);  C = mk(3);  D = mk(4);
        E = mk(5);  F = mk(6);  G = mk(7);  H = mk(8);
        I = mk(9);  J = mk(10); K = mk(11); L = mk(12);
        M = mk(13); N = mk(14);

        rst = 1'b1; flush = 1'b0; in_valid = '0; win_used = '0; in_ops = '0;
        tick(); tick();
        chk("rst_valid", 256'(win_valid), 256'(4'b0000));
        chk("rst_occ", 256'(occupancy), 256'(3'd0));
        chk("rst_ops", 256'(win_ops), 256'(0));
        chk("rst_ready", 256'(in_ready), 256'(1'b0));

        rst = 1'b0;
        in_valid = 4'b1111; in_ops = {D, C, B, A};
        #1 chk("fill_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("fill_valid", 256'(win_valid), 256'(4'b1111));
        chk("fill_ops", 256'(win_ops), 256'({D, C, B, A}));
        chk("fill_occ", 256'(occupancy), 256'(3'd4));

        win_used = 4'b0101; in_valid = 4'b0011; in_ops = {OW'(0), OW'(0), F, E};
        #1 chk("c0101_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("c0101_ops", 256'(win_ops), 256'({F, E, D, B}));
        chk("c0101_valid", 256'(win_valid), 256'(4'b1111));

        win_used = 4'b0001; in_valid = 4'b0011; in_ops = {OW'(0), OW'(0), H, G};
        #1 chk("stall_ready", 256'(in_ready), 256'(1'b0));
        tick();
        lo3 = win_ops[3*OW-1:0];
        chk("stall_ops", 256'(lo3), 256'({F, E, D}));
        chk("stall_valid", 256'(win_valid), 256'(4'b0111));
        chk("stall_occ", 256'(occupancy), 256'(3'd3));

        win_used = 4'b0000;
        #1 chk("hold_ready", 256'(in_ready), 256'(1'b0));
        tick();
        lo3 = win_ops[3*OW-1:0];
        chk("hold_ops", 256'(lo3), 256'({F, E, D}));
        chk("hold_valid", 256'(win_valid), 256'(4'b0111));

        win_used = 4'b0001;
        #1 chk("retry_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("retry_ops", 256'(win_ops), 256'({H, G, F, E}));
        chk("retry_valid", 256'(win_valid), 256'(4'b1111));
        chk("retry_occ", 256'(occupancy), 256'(3'd4));

        win_used = 4'b0011; in_valid = 4'b0000; in_ops = '0;
        #1 chk("idle_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("drain_valid", 256'(win_valid), 256'(4'b0011));
        chk("drain_ops", 256'(win_ops[2*OW-1:0]), 256'({H, G}));

        win_used = 4'b1100;
        tick();
        chk("ghost_valid", 256'(win_valid), 256'(4'b0011));
        chk("ghost_ops", 256'(win_ops[2*OW-1:0]), 256'({H, G}));
        chk("ghost_occ", 256'(occupancy), 256'(3'd2));

        win_used = 4'b0000; in_valid = 4'b0001; in_ops = {OW'(0), OW'(0), OW'(0), I};
        tick();
        in_ops = {OW'(0), OW'(0), OW'(0), J};
        tick();
        chk("top_ops", 256'(win_ops), 256'({J, I, H, G}));
        chk("top_occ", 256'(occupancy), 256'(3'd4));

        win_used = 4'b1111; in_valid = 4'b1111; in_ops = {N, M, L, K};
        #1 chk("swap_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("swap_ops", 256'(win_ops), 256'({N, M, L, K}));
        chk("swap_valid", 256'(win_valid), 256'(4'b1111));

        win_used = 4'b0000; flush = 1'b1; in_ops = {D, C, B, A};
        #1 chk("flush_ready", 256'(in_ready), 256'(1'b0));
        tick();
        chk("flush_valid", 256'(win_valid), 256'(4'b0000));
        chk("flush_occ", 256'(occupancy), 256'(3'd0));

        flush = 1'b0; in_valid = 4'b0000;
        #1 chk("empty_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("empty_valid", 256'(win_valid), 256'(4'b0000));
        chk("empty_occ", 256'(occupancy), 256'(3'd0));

        in_valid = 4'b0111; in_ops = {OW'(0), C, B, A};
        tick();
        chk("abc_valid", 256'(win_valid), 256'(4'b0111));

        rst = 1'b1; win_used = 4'b0111; in_valid = 4'b0001;
        in_ops = {OW'(0), OW'(0), OW'(0), D};
        #1 chk("mrst_ready", 256'(in_ready), 256'(1'b0));
        tick();
        chk("mrst_valid", 256'(win_valid), 256'(4'b0000));
        chk("mrst_ops", 256'(win_ops), 256'(0));
        chk("mrst_occ", 256'(occupancy), 256'(3'd0));

        rst = 1'b0; win_used = 4'b0000;
        #1 chk("post_ready", 256'(in_ready), 256'(1'b1));
        tick();
        chk("post_valid", 256'(win_valid), 256'(4'b0001));
        chk("post_ops", 256'(win_ops[OW-1:0]), 256'(D));

        in_valid = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
